// File: rtl/ppu_pkg.sv
// ppu_pkg -- shared types, constants and helpers for the posit encode path.
//
// Posit geometry comes from the `N / `ES macros (defaults 16 / 1) so every
// file that imports this package agrees on the same widths.
//   ops_out_meta_t  : unrounded result from the ops stage
//                     (sign, total_exponent, fraction bits below the hidden
//                     one, frac_truncated = nonzero bits already lost)
//   posit_special_t : special_tag=1 means posit already holds the final
//                     encoding (ZERO / NAR)
//   c2()            : two's complement, used to apply the sign
`ifndef N
`define N 16
`endif
`ifndef ES
`define ES 1
`endif

package ppu_pkg;

  localparam int POSIT_N  = `N;
  localparam int POSIT_ES = `ES;

  // Regime value k after clamping spans +/-(N-2); one extra bit leaves room
  // for unclamped k coming out of the exponent shift.
  localparam int K_BITS         = $clog2(POSIT_N) + 2;
  localparam int TE_BITS        = K_BITS + POSIT_ES;
  localparam int FRAC_FULL_SIZE = POSIT_N;

  localparam logic [POSIT_N-1:0] ZERO   = '0;
  localparam logic [POSIT_N-1:0] NAR    = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] MAXPOS = {1'b0, {(POSIT_N-1){1'b1}}};
  localparam logic [POSIT_N-1:0] MINPOS = POSIT_N'(1);

  typedef struct packed {
    logic                        sign;
    logic signed [TE_BITS-1:0]   total_exponent;
    logic [FRAC_FULL_SIZE-1:0]   frac;
    logic                        frac_truncated;
  } ops_out_meta_t;

  typedef struct packed {
    logic               special_tag;
    logic [POSIT_N-1:0] posit;
  } posit_special_t;

  function automatic logic [POSIT_N-1:0] c2(input logic [POSIT_N-1:0] x);
    return ~x + POSIT_N'(1);
  endfunction

endpackage

// File: rtl/posit_round.sv
// posit_round -- combinational round / saturate / sign / special select.
//
// Ports:
//   sign           result sign (1 = negate the positive encoding)
//   body           kept N-1 bits of regime++exp++frac
//   guard, sticky  first dropped bit, OR of everything below it
//   sat_hi, sat_lo regime was clamped high / low upstream
//   special_tag    1 = pass special_posit through untouched
//   special_posit  final encoding for ZERO / NAR
//   posit          encoded, rounded posit
//   inexact        (PPU_INEXACT_FLAG_EN only) result is not exact
module posit_round
  import ppu_pkg::*;
#(
  parameter int N = POSIT_N
) (
  input  logic         sign,
  input  logic [N-2:0] body,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sat_hi,
  input  logic         sat_lo,
  input  logic         special_tag,
  input  logic [N-1:0] special_posit,
  output logic [N-1:0] posit
`ifdef PPU_INEXACT_FLAG_EN
  ,
  output logic         inexact
`endif
);

  logic         round_up;
  logic [N-1:0] sum;
  logic         ovf;
  logic         unf;
  logic [N-1:0] mag;

  // Nearest, ties to even.
  assign round_up = guard & (body[0] | sticky);
  // One spare MSB catches a carry out of the body.
  assign sum = {1'b0, body} + {{(N-1){1'b0}}, round_up};
  assign ovf = sat_hi | sum[N-1];
  // A non-special result never encodes as zero; clamp it to minpos instead.
  assign unf = sat_lo | ~(|sum[N-2:0]);

  always_comb begin
    if (ovf) begin
      mag = MAXPOS;
    end else if (unf) begin
      mag = MINPOS;
    end else begin
      mag = sum;
    end

    if (special_tag) begin
      posit = special_posit;
    end else if (sign) begin
      posit = c2(mag);
    end else begin
      posit = mag;
    end
  end

`ifdef PPU_INEXACT_FLAG_EN
  assign inexact = ~special_tag & (guard | sticky | ovf | unf);
`endif

endmodule

// File: rtl/fir_to_posit_pipe.sv
// fir_to_posit_pipe -- two-stage posit encoder with valid/ready handshake.
//   S1: regime k and exponent from total_exponent, clamp k, build and shift
//       the body, split into kept bits / guard / sticky.
//   S2: round, saturate, apply sign, select special (posit_round).
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   in_valid_i      upstream result valid
//   in_ready_o      pipe can take an input this cycle (combinational)
//   ops_out_i       unrounded sign / total_exponent / frac / frac_truncated
//   special_i       special_tag=1 -> posit field is the final answer
//   out_valid_o     posit_o valid
//   out_ready_i     downstream takes the result
//   posit_o         encoded, rounded posit
//   inexact_o       only when PPU_INEXACT_FLAG_EN is defined
//
// N and ES must match the package geometry (ppu_pkg POSIT_N / POSIT_ES);
// ES >= 1 is assumed.
module fir_to_posit_pipe
  import ppu_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  ops_out_meta_t  ops_out_i,
  input  posit_special_t special_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N-1:0]   posit_o
`ifdef PPU_INEXACT_FLAG_EN
  ,
  output logic           inexact_o
`endif
);

  localparam int F    = FRAC_FULL_SIZE;
  localparam int W    = N + ES + F;
  localparam int KMAX = N - 2;
  localparam int SH_W = $clog2(N + 1);

  // ---------------- S1 combinational ----------------
  logic signed [K_BITS-1:0] k_raw;
  int                       k_int;
  int                       reg_len;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [N-1:0]             regime_bits;
  logic [SH_W-1:0]          shift_amt;
  logic [W-1:0]             body_pre;
  logic [W-1:0]             body_sh;

  assign k_raw = K_BITS'($signed(ops_out_i.total_exponent) >>> ES);

  always_comb begin
    k_int  = int'(k_raw);
    sat_hi = 1'b0;
    sat_lo = 1'b0;
    if (k_int > KMAX) begin
      k_int  = KMAX;
      sat_hi = 1'b1;
    end else if (k_int < -KMAX) begin
      k_int  = -KMAX;
      sat_lo = 1'b1;
    end
    // k>=0: k+1 ones then a zero; k<0: -k zeros then a one.
    reg_len   = (k_int >= 0) ? (k_int + 2) : (1 - k_int);
    shift_amt = SH_W'(N - reg_len);
  end

  // Regime pattern right-aligned in N bits; the left shift below moves its
  // first bit to the top of the body.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_regime
      assign regime_bits[gi] = (k_int < 0) ? (gi == 0)
                                           : ((gi >= 1) && (gi <= k_int + 1));
    end
  endgenerate

  assign body_pre = {regime_bits, ops_out_i.total_exponent[ES-1:0], ops_out_i.frac};
  assign body_sh  = body_pre << shift_amt;

  // ---------------- pipeline control ----------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv     = ~s2_valid_reg | out_ready_i;
  assign s1_adv     = ~s1_valid_reg | s2_adv;
  assign in_ready_o = s1_adv;

  // ---------------- S1 registers ----------------
  logic [N-2:0]   s1_body_reg;
  logic           s1_guard_reg;
  logic           s1_sticky_reg;
  logic           s1_sign_reg;
  logic           s1_sat_hi_reg;
  logic           s1_sat_lo_reg;
  posit_special_t s1_special_reg;

  // ---------------- S2 ----------------
  logic [N-1:0] round_posit;
  logic [N-1:0] posit_reg;
`ifdef PPU_INEXACT_FLAG_EN
  logic         round_inexact;
  logic         inexact_reg;
`endif

  posit_round #(
    .N (N)
  ) u_round (
    .sign          (s1_sign_reg),
    .body          (s1_body_reg),
    .guard         (s1_guard_reg),
    .sticky        (s1_sticky_reg),
    .sat_hi        (s1_sat_hi_reg),
    .sat_lo        (s1_sat_lo_reg),
    .special_tag   (s1_special_reg.special_tag),
    .special_posit (s1_special_reg.posit),
    .posit         (round_posit)
`ifdef PPU_INEXACT_FLAG_EN
    ,
    .inexact       (round_inexact)
`endif
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s1_body_reg    <= '0;
      s1_guard_reg   <= 1'b0;
      s1_sticky_reg  <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_sat_hi_reg  <= 1'b0;
      s1_sat_lo_reg  <= 1'b0;
      s1_special_reg <= '0;
      posit_reg      <= ZERO;
`ifdef PPU_INEXACT_FLAG_EN
      inexact_reg    <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= in_valid_i;
        if (in_valid_i) begin
          s1_body_reg    <= body_sh[W-1 -: N-1];
          s1_guard_reg   <= body_sh[W-N];
          s1_sticky_reg  <= (|body_sh[W-N-1:0]) | ops_out_i.frac_truncated;
          s1_sign_reg    <= ops_out_i.sign;
          s1_sat_hi_reg  <= sat_hi;
          s1_sat_lo_reg  <= sat_lo;
          s1_special_reg <= special_i;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        // Output data only moves with a real transfer, so a stalled result
        // stays put.
        if (s1_valid_reg) begin
          posit_reg   <= round_posit;
`ifdef PPU_INEXACT_FLAG_EN
          inexact_reg <= round_inexact;
`endif
        end
      end
    end
  end

  assign out_valid_o = s2_valid_reg;
  assign posit_o     = posit_reg;
`ifdef PPU_INEXACT_FLAG_EN
  assign inexact_o   = inexact_reg;
`endif

endmodule

// File: tb/tb_fir_to_posit_pipe.sv
// Self-checking bench for fir_to_posit_pipe (N=16, ES=1).
// Expected encodings are hand-derived constants in the vector table; a
// queue scoreboard matches them against outputs in order.
module tb_fir_to_posit_pipe;
  import ppu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  ops_out_meta_t  ops;
  posit_special_t spec;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    posit;
  logic           inexact_obs;

  always #5 clk = ~clk;

`ifdef PPU_INEXACT_FLAG_EN
  localparam bit FLAG = 1'b1;
  logic inexact;
  assign inexact_obs = inexact;
`else
  localparam bit FLAG = 1'b0;
  assign inexact_obs = 1'b0;
`endif

  fir_to_posit_pipe dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ops_out_i   (ops),
    .special_i   (spec),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .posit_o     (posit)
`ifdef PPU_INEXACT_FLAG_EN
    ,
    .inexact_o   (inexact)
`endif
  );

  typedef struct {
    bit          sign;
    int          te;
    logic [15:0] frac;
    bit          ft;
    bit          tag;
    logic [15:0] sp;
    logic [15:0] exp_p;
    bit          exp_x;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic vec_t mk(bit s, int te, logic [15:0] fr, bit ft, bit tag,
                              logic [15:0] sp, logic [15:0] ep, bit ex);
    vec_t v;
    v.sign = s; v.te = te; v.frac = fr; v.ft = ft; v.tag = tag;
    v.sp = sp; v.exp_p = ep; v.exp_x = ex;
    return v;
  endfunction

  // {inexact, posit}; the flag bit is expected 0 when the port is absent.
  function automatic logic [16:0] expect_of(vec_t v);
    return {FLAG ? v.exp_x : 1'b0, v.exp_p};
  endfunction

  task automatic drive_vec(input vec_t v);
    ops.sign           = v.sign;
    ops.total_exponent = TE_BITS'(v.te);
    ops.frac           = v.frac;
    ops.frac_truncated = v.ft;
    spec.special_tag   = v.tag;
    spec.posit         = v.sp;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(output bit inf, output bit outf, output bit ov,
                      output logic [16:0] obs);
    #1;
    inf  = in_valid && in_ready;
    ov   = out_valid;
    outf = out_valid && out_ready;
    obs  = {inexact_obs, posit};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_vec(mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0));
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (posit !== ZERO) begin
      n_bad++; $display("FAIL reset_posit: got %h want %h", posit, ZERO);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef PPU_INEXACT_FLAG_EN
    n_vec++;
    if (inexact_obs !== 1'b0) begin
      n_bad++; $display("FAIL reset_inexact: got %b want 0", inexact_obs);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_function();
    int idx = 0;
    int cyc = 0;
    bit inf, outf, ov;
    logic [16:0] obs, e;
    sb.delete();
    out_ready = 1'b1;
    while ((idx < vecs.size() || sb.size() > 0) && cyc < 500) begin
      if (idx < vecs.size()) begin
        in_valid = 1'b1;
        drive_vec(vecs[idx]);
      end else begin
        in_valid = 1'b0;
      end
      step(inf, outf, ov, obs);
      if (inf) begin
        sb.push_back(expect_of(vecs[idx]));
        idx++;
      end
      if (outf) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL func_extra: got %h want none", obs);
        end else begin
          e = sb.pop_front();
          $display("func out %h exp %h", obs, e);
          if (obs !== e) begin
            n_bad++; $display("FAIL func_result: got %h want %h", obs, e);
          end
        end
      end
      cyc++;
    end
    n_vec++;
    if (cyc >= 500) begin
      n_bad++; $display("FAIL func_timeout: got %0d pending want 0", sb.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int cyc = 0;
    int bb[3] = '{12, 13, 14};
    bit inf, outf, ov;
    logic [16:0] obs, e, first;
    sb.delete();
    first = expect_of(vecs[bb[0]]);
    while ((acc < 3 || sb.size() > 0) && cyc < 60) begin
      out_ready = (cyc >= 6);
      if (acc < 3) begin
        in_valid = 1'b1;
        drive_vec(vecs[bb[acc]]);
      end else begin
        in_valid = 1'b0;
      end
      step(inf, outf, ov, obs);
      if (cyc < 3) begin
        n_vec++;
        if (inf !== (cyc < 2)) begin
          n_bad++; $display("FAIL bb_accept[%0d]: got %b want %b", cyc, inf, (cyc < 2));
        end
      end
      if (cyc >= 2 && cyc < 6) begin
        n_vec++;
        if (!ov || obs !== first) begin
          n_bad++; $display("FAIL bb_hold[%0d]: got v=%b %h want v=1 %h", cyc, ov, obs, first);
        end
      end
      if (inf) begin
        sb.push_back(expect_of(vecs[bb[acc]]));
        acc++;
      end
      if (outf) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL bb_extra: got %h want none", obs);
        end else begin
          e = sb.pop_front();
          $display("bb out %h exp %h", obs, e);
          if (obs !== e) begin
            n_bad++; $display("FAIL bb_result: got %h want %h", obs, e);
          end
        end
      end
      cyc++;
    end
    n_vec++;
    if (cyc >= 60) begin
      n_bad++; $display("FAIL bb_timeout: got %0d pending want 0", sb.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_stall();
    int idx = 0;
    int cyc = 0;
    bit inf, outf, ov, held;
    logic [16:0] obs, e, held_p;
    sb.delete();
    held = 1'b0;
    held_p = '0;
    while ((idx < vecs.size() || sb.size() > 0) && cyc < 2000) begin
      out_ready = ($urandom_range(0, 9) < 6);
      if (idx < vecs.size() && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        drive_vec(vecs[idx]);
      end else begin
        in_valid = 1'b0;
      end
      step(inf, outf, ov, obs);
      if (held) begin
        n_vec++;
        if (!ov || obs !== held_p) begin
          n_bad++; $display("FAIL rs_hold: got v=%b %h want v=1 %h", ov, obs, held_p);
        end
      end
      held   = ov && !outf;
      held_p = obs;
      if (inf) begin
        sb.push_back(expect_of(vecs[idx]));
        idx++;
      end
      if (outf) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rs_extra: got %h want none", obs);
        end else begin
          e = sb.pop_front();
          $display("rs out %h exp %h", obs, e);
          if (obs !== e) begin
            n_bad++; $display("FAIL rs_result: got %h want %h", obs, e);
          end
        end
      end
      cyc++;
    end
    n_vec++;
    if (cyc >= 2000) begin
      n_bad++; $display("FAIL rs_timeout: got %0d pending want 0", sb.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int idx = 0;
    bit inf, outf, ov;
    logic [16:0] obs, e;
    sb.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_vec(vecs[0]);
    step(inf, outf, ov, obs);
    drive_vec(vecs[1]);
    step(inf, outf, ov, obs);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rm_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rm_async_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rm_async_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    // One post-reset input, then a few idle cycles to catch stale outputs.
    while (cyc < 12) begin
      if (idx < 1) begin
        in_valid = 1'b1;
        drive_vec(vecs[15]);
      end else begin
        in_valid = 1'b0;
      end
      step(inf, outf, ov, obs);
      if (inf) begin
        sb.push_back(expect_of(vecs[15]));
        idx++;
      end
      if (outf) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rm_extra: got %h want none", obs);
        end else begin
          e = sb.pop_front();
          $display("rm out %h exp %h", obs, e);
          if (obs !== e) begin
            n_bad++; $display("FAIL rm_result: got %h want %h", obs, e);
          end
        end
      end
      cyc++;
    end
    n_vec++;
    if (idx != 1 || sb.size() != 0) begin
      n_bad++; $display("FAIL rm_drain: got acc=%0d pending=%0d want acc=1 pending=0", idx, sb.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    //                 s  te   frac    ft tag sp       exp      x
    vecs.push_back(mk(0,   0, 16'h0000, 0, 0, 16'h0000, 16'h4000, 0)); // 0
    vecs.push_back(mk(1,   0, 16'h0000, 0, 0, 16'h0000, 16'hC000, 0)); // 1
    vecs.push_back(mk(0,   0, 16'h0008, 0, 0, 16'h0000, 16'h4000, 1)); // 2 tie->even
    vecs.push_back(mk(0,   0, 16'h0008, 1, 0, 16'h0000, 16'h4001, 1)); // 3 sticky
    vecs.push_back(mk(0,   0, 16'h0018, 0, 0, 16'h0000, 16'h4002, 1)); // 4 tie, odd lsb
    vecs.push_back(mk(0,  40, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 1)); // 5
    vecs.push_back(mk(0, -40, 16'h0000, 0, 0, 16'h0000, 16'h0001, 1)); // 6
    vecs.push_back(mk(1, -40, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 1)); // 7
    vecs.push_back(mk(0,  28, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 0)); // 8 exact maxpos
    vecs.push_back(mk(0,  29, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 1)); // 9
    vecs.push_back(mk(0, -28, 16'h0000, 0, 0, 16'h0000, 16'h0001, 0)); // 10 exact minpos
    vecs.push_back(mk(0,  30, 16'h0000, 0, 0, 16'h0000, 16'h7FFF, 1)); // 11 k clamps
    vecs.push_back(mk(0,   1, 16'h0000, 0, 0, 16'h0000, 16'h5000, 0)); // 12
    vecs.push_back(mk(0,  -1, 16'h0000, 0, 0, 16'h0000, 16'h3000, 0)); // 13
    vecs.push_back(mk(0,   2, 16'h0000, 0, 0, 16'h0000, 16'h6000, 0)); // 14
    vecs.push_back(mk(0,   0, 16'h8000, 0, 0, 16'h0000, 16'h4800, 0)); // 15
    vecs.push_back(mk(1,   1, 16'h0000, 0, 0, 16'h0000, 16'hB000, 0)); // 16
    vecs.push_back(mk(0,   5, 16'h0000, 0, 1, 16'h8000, 16'h8000, 0)); // 17 NAR
    vecs.push_back(mk(0,   0, 16'h0008, 1, 1, 16'h0000, 16'h0000, 0)); // 18 ZERO

    test_reset();
    test_function();
    test_back_to_back();
    test_random_stall();
    test_random_stall();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
